// File: rtl/baccarat_ctrl.sv
// Baccarat sequencing controller: betting phase, deal strobes,
// natural/third-card rules and a single settle pulse per hand.
module baccarat_ctrl (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       confirm,
   input  logic [1:0] bet_sw,
   input  logic [7:0] wager_sw,
   input  logic [7:0] balance,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       betting,
   output logic       load_wager,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic [1:0] result,
   output logic [1:0] winner,
   output logic       bet_error,
   output logic       broke
);

   typedef enum logic [3:0] {
      BET, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK,
      DEAL_P3, BANKER, DEAL_D3, SCORE, DONE, BROKE
   } state_t;

   state_t     state, next;
   logic       valid;
   logic       natural;
   logic       banker_draw;
   logic [3:0] v;
   logic [1:0] score_res;

   assign valid = (bet_sw == 2'b00) ||
                  ((wager_sw != 8'd0) && (wager_sw <= balance));
   assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);
   assign v = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

   always_comb begin
      if (pscore > dscore)
         score_res = 2'b01;
      else if (dscore > pscore)
         score_res = 2'b10;
      else
         score_res = 2'b11;
   end

   // Banker tableau once the player has taken a third card
   always_comb begin
      banker_draw = 1'b0;
      unique case (1'b1)
         (dscore <= 4'd2): banker_draw = 1'b1;
         (dscore == 4'd3): banker_draw = (v != 4'd8);
         (dscore == 4'd4): banker_draw = (v >= 4'd2) && (v <= 4'd7);
         (dscore == 4'd5): banker_draw = (v >= 4'd4) && (v <= 4'd7);
         (dscore == 4'd6): banker_draw = (v >= 4'd6) && (v <= 4'd7);
         default:          banker_draw = 1'b0;
      endcase
   end

   always_ff @(posedge slow_clock or posedge resetb) begin
      if (resetb)
         state <= BET;
      else
         state <= next;
   end

   always_comb begin
      next        = state;
      betting     = 1'b0;
      load_wager  = 1'b0;
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      result      = 2'b00;
      bet_error   = 1'b0;
      broke       = 1'b0;
      unique case (state)
         BET: begin
            betting    = 1'b1;
            bet_error  = ~valid;
            load_wager = confirm & valid;
            if (confirm & valid)
               next = DEAL_P1;
         end
         DEAL_P1: begin
            load_pcard1 = 1'b1;
            next        = DEAL_D1;
         end
         DEAL_D1: begin
            load_dcard1 = 1'b1;
            next        = DEAL_P2;
         end
         DEAL_P2: begin
            load_pcard2 = 1'b1;
            next        = DEAL_D2;
         end
         DEAL_D2: begin
            load_dcard2 = 1'b1;
            next        = CHECK;
         end
         CHECK: begin
            if (natural)
               next = SCORE;
            else if (pscore <= 4'd5)
               next = DEAL_P3;
            else if (dscore <= 4'd5)
               next = DEAL_D3;
            else
               next = SCORE;
         end
         DEAL_P3: begin
            load_pcard3 = 1'b1;
            next        = BANKER;
         end
         BANKER: begin
            next = banker_draw ? DEAL_D3 : SCORE;
         end
         DEAL_D3: begin
            load_dcard3 = 1'b1;
            next        = SCORE;
         end
         SCORE: begin
            result = score_res;
            next   = DONE;
         end
         DONE: begin
            if (balance == 8'd0)
               next = BROKE;
            else if (confirm)
               next = BET;
         end
         BROKE: begin
            broke = 1'b1;
         end
         default: next = BET;
      endcase
   end

   always_ff @(posedge slow_clock or posedge resetb) begin
      if (resetb)
         winner <= 2'b00;
      else if (load_wager)
         winner <= 2'b00;
      else if (state == SCORE)
         winner <= score_res;
   end

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Scoreboard bench for baccarat_ctrl: expected strobe/result events
// with cycle gaps are queued by stimulus and checked by a monitor.
module tb_baccarat_ctrl;

   logic       slow_clock = 1'b0;
   logic       resetb;
   logic       confirm;
   logic [1:0] bet_sw;
   logic [7:0] wager_sw;
   logic [7:0] balance;
   logic [3:0] pscore, dscore, pcard3;
   logic       betting, load_wager;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic [1:0] result, winner;
   logic       bet_error, broke;

   logic       bal_wr;
   logic [7:0] bal_init;
   logic [7:0] settle_bal;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      logic [8:0] ev;
      int         gap;
   } exp_t;
   exp_t exp_q[$];

   localparam logic [8:0] E_LW  = 9'b00_1000000;
   localparam logic [8:0] E_P1  = 9'b00_0100000;
   localparam logic [8:0] E_D1  = 9'b00_0010000;
   localparam logic [8:0] E_P2  = 9'b00_0001000;
   localparam logic [8:0] E_D2  = 9'b00_0000100;
   localparam logic [8:0] E_P3  = 9'b00_0000010;
   localparam logic [8:0] E_D3  = 9'b00_0000001;
   localparam logic [8:0] E_R01 = 9'b01_0000000;
   localparam logic [8:0] E_R10 = 9'b10_0000000;
   localparam logic [8:0] E_R11 = 9'b11_0000000;
   localparam logic [8:0] E_RES = 9'b11_0000000;

   logic [8:0] ev_now;
   assign ev_now = {result, load_wager, load_pcard1, load_dcard1,
                    load_pcard2, load_dcard2, load_pcard3, load_dcard3};

   baccarat_ctrl dut (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .confirm    (confirm),
      .bet_sw     (bet_sw),
      .wager_sw   (wager_sw),
      .balance    (balance),
      .pscore     (pscore),
      .dscore     (dscore),
      .pcard3     (pcard3),
      .betting    (betting),
      .load_wager (load_wager),
      .load_pcard1(load_pcard1),
      .load_pcard2(load_pcard2),
      .load_pcard3(load_pcard3),
      .load_dcard1(load_dcard1),
      .load_dcard2(load_dcard2),
      .load_dcard3(load_dcard3),
      .result     (result),
      .winner     (winner),
      .bet_error  (bet_error),
      .broke      (broke)
   );

   always #5 slow_clock = ~slow_clock;

   always @(posedge slow_clock) cyc <= cyc + 1;

   // Minimal datapath: balance settles on the edge leaving SCORE
   always @(posedge slow_clock) begin
      if (bal_wr)
         balance <= bal_init;
      else if (result != 2'b00)
         balance <= settle_bal;
   end

   task automatic push(input logic [8:0] ev, input int gap);
      exp_t e;
      e.ev  = ev;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic push_deal();
      push(E_LW, 0);
      push(E_P1, 1);
      push(E_D1, 1);
      push(E_P2, 1);
      push(E_D2, 1);
   endtask

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge slow_clock);
      #1;
   endtask

   task automatic wait_ev(input logic [8:0] mask, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge slow_clock);
         if ((ev_now & mask) != 9'd0) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         fails++;
         $display("FAIL timeout %s: got no event expected event", name);
      end
   endtask

   // Monitor: every nonzero strobe/result vector must match the queue head
   initial begin
      exp_t e;
      int   last;
      last = 0;
      forever begin
         @(negedge slow_clock);
         if (ev_now != 9'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event: got %b expected none", ev_now);
            end else begin
               e = exp_q.pop_front();
               if (ev_now !== e.ev) begin
                  fails++;
                  $display("FAIL event: got %b expected %b", ev_now, e.ev);
               end
               if (e.gap != 0) begin
                  checks++;
                  if (cyc - last != e.gap) begin
                     fails++;
                     $display("FAIL gap %b: got %0d expected %0d",
                              e.ev, cyc - last, e.gap);
                  end
               end
            end
            last = cyc;
         end
      end
   end

   task automatic next_hand();
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      chk("back_to_bet", {15'd0, betting}, 16'd1);
   endtask

   initial begin
      resetb     = 1'b1;
      confirm    = 1'b0;
      bet_sw     = 2'b00;
      wager_sw   = 8'd0;
      pscore     = 4'd0;
      dscore     = 4'd0;
      pcard3     = 4'd0;
      bal_wr     = 1'b1;
      bal_init   = 8'd16;
      settle_bal = 8'd0;
      repeat (3) tick();
      resetb = 1'b0;
      bal_wr = 1'b0;

      chk("rst_betting", {15'd0, betting}, 16'd1);
      chk("rst_winner",  {14'd0, winner}, 16'd0);
      chk("rst_result",  {14'd0, result}, 16'd0);
      chk("rst_broke",   {15'd0, broke}, 16'd0);
      chk("rst_strobes", {7'd0, ev_now}, 16'd0);

      wager_sw = 8'd20;
      #1 chk("no_bet_valid", {15'd0, bet_error}, 16'd0);
      bet_sw = 2'b01;
      wager_sw = 8'd0;
      #1 chk("zero_wager_err", {15'd0, bet_error}, 16'd1);
      wager_sw = 8'd16;
      #1 chk("wager_eq_bal_ok", {15'd0, bet_error}, 16'd0);
      wager_sw = 8'd20;
      confirm = 1'b1;
      #1 chk("over_bal_err", {15'd0, bet_error}, 16'd1);
      tick();
      tick();
      chk("stay_in_bet", {15'd0, betting}, 16'd1);

      // Hand 0: reset lands in DEAL_D2
      push(E_LW, 0);
      push(E_P1, 1);
      push(E_D1, 1);
      push(E_P2, 1);
      pscore = 4'd8;
      dscore = 4'd3;
      wager_sw = 8'd5;
      #1 chk("wager5_ok", {15'd0, bet_error}, 16'd0);
      tick();
      confirm = 1'b0;
      wait_ev(E_P2, "p2_before_reset");
      tick();
      resetb = 1'b1;
      #1;
      chk("midrst_betting", {15'd0, betting}, 16'd1);
      chk("midrst_strobes", {7'd0, ev_now}, 16'd0);
      chk("midrst_winner",  {14'd0, winner}, 16'd0);
      tick();
      tick();
      resetb = 1'b0;

      // Hand 1: player natural
      push_deal();
      push(E_R01, 2);
      settle_bal = 8'd21;
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      wait_ev(E_RES, "h1_result");
      tick();
      chk("h1_winner", {14'd0, winner}, 16'd1);
      chk("h1_result_off", {14'd0, result}, 16'd0);
      chk("h1_broke", {15'd0, broke}, 16'd0);
      next_hand();
      chk("h1_winner_held", {14'd0, winner}, 16'd1);

      // Hand 2: player draws face card, banker draws, tie
      push_deal();
      push(E_P3, 2);
      push(E_D3, 2);
      push(E_R11, 1);
      bet_sw = 2'b11;
      pscore = 4'd4;
      dscore = 4'd3;
      pcard3 = 4'd12;
      settle_bal = 8'd61;
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      chk("h2_winner_clr", {14'd0, winner}, 16'd0);
      wait_ev(E_D3, "h2_d3");
      dscore = 4'd4;
      wait_ev(E_RES, "h2_result");
      tick();
      chk("h2_winner", {14'd0, winner}, 16'd3);
      next_hand();

      // Hand 3: player draws an 8, banker on 3 stands
      push_deal();
      push(E_P3, 2);
      push(E_R10, 2);
      bet_sw = 2'b10;
      pscore = 4'd2;
      dscore = 4'd3;
      pcard3 = 4'd8;
      settle_bal = 8'd66;
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      wait_ev(E_RES, "h3_result");
      tick();
      chk("h3_winner", {14'd0, winner}, 16'd2);
      next_hand();

      // Hand 4: player stands on 6, banker draws, balance wiped out
      push_deal();
      push(E_D3, 2);
      push(E_R10, 1);
      bet_sw = 2'b01;
      wager_sw = 8'd66;
      pscore = 4'd6;
      dscore = 4'd5;
      pcard3 = 4'd0;
      settle_bal = 8'd0;
      #1 chk("h4_wager_eq_bal", {15'd0, bet_error}, 16'd0);
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      wait_ev(E_D3, "h4_d3");
      dscore = 4'd7;
      wait_ev(E_RES, "h4_result");
      tick();
      chk("h4_done_broke", {15'd0, broke}, 16'd0);
      chk("h4_winner", {14'd0, winner}, 16'd2);
      tick();
      chk("h4_broke", {15'd0, broke}, 16'd1);
      chk("h4_not_betting", {15'd0, betting}, 16'd0);
      confirm = 1'b1;
      repeat (4) tick();
      confirm = 1'b0;
      chk("broke_sticky", {15'd0, broke}, 16'd1);
      chk("broke_no_bet", {15'd0, betting}, 16'd0);

      repeat (2) tick();
      chk("queue_drained", exp_q.size(), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
